bcd_scan_counter: RTL

- Upstream feeder for the 7-segment decoder: a 4-digit BCD up/down counter with a built-in display multiplexer.
- Each cycle it presents one 4-bit BCD digit code, which drives the decoder's 4-bit `sin` input, plus a one-hot digit-select that enables the matching display position.
- A count prescaler sets the counting rate; a scan prescaler sets the refresh rate.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 34 +++
 rtl/bcd_scan_counter.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD scan counter and its digit cells.
// Optional build: LEADING_ZERO_BLANK_EN enables leading-zero blanking.
package seg_pkg;

    localparam int DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [DIGITS-1:0] bcd_word_t;

    function automatic bcd_t bcd_sat(input bcd_t n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t n);
        return (n >= BCD_MAX) ? 4'd0 : n + 4'd1;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t n);
        return (n == 4'd0) ? BCD_MAX : n - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD nibble of the ripple counter: clear, sanitised load, up/down step.
// step_out is the carry (up) or borrow (down) into the next digit.
module bcd_digit
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_nibble,
    output logic [3:0] q,
    output logic       step_out
);

    logic wrap;

    assign wrap     = up ? (q == BCD_MAX) : (q == 4'd0);
    assign step_out = step_in & wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (load) begin
            q <= bcd_sat(load_nibble);
        end else if (step_in) begin
            q <= up ? bcd_inc(q) : bcd_dec(q);
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// 4-digit BCD up/down counter with a multiplexed digit/anode scan output.
// Optional build: LEADING_ZERO_BLANK_EN blanks zero digits above the MSD.
module bcd_scan_counter
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic [15:0] value,
    output logic        carry
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          step0;
    logic [DIGITS:0] step;
    bcd_word_t     val_w;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    bcd_t          code;

    // Count prescaler: en freezes it, clr restarts it, load leaves it running
    assign tick = en && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign step0   = tick & ~clr & ~load;
    assign step[0] = step0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .clk         (clk),
            .rst         (rst),
            .step_in     (step[g]),
            .up          (up),
            .clr         (clr),
            .load        (load),
            .load_nibble (load_val[4*g +: 4]),
            .q           (val_w[g]),
            .step_out    (step[g+1])
        );
    end

    assign value = val_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else begin
            carry <= step[DIGITS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic keep;

    // A digit shows if it is the ones digit or any digit at/above it is non-zero
    always_comb begin
        keep = (idx == 2'd0);
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx) && val_w[j] != 4'd0) begin
                keep = 1'b1;
            end
        end
        code = keep ? val_w[idx] : BLANK_CODE;
    end
`else
    assign code = val_w[idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= 4'b0001;
            digit <= 4'h0;
        end else begin
            an    <= 4'b0001 << idx;
            digit <= code;
        end
    end

endmodule
